// File: rtl/timer_mmss_pkg.sv
// Shared definitions for the MM:SS countdown timer.
//   state_e    : control FSM encoding (IDLE, RUN, PAUSE)
//   *_MOD      : per-digit moduli (seconds units, seconds tens, minute digits)
//   DIGIT_W    : width of one BCD digit
//   digit_mod(): modulus of digit position idx (0 = seconds units, upward)
package timer_mmss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int SEC_U_MOD = 10;
  localparam int SEC_T_MOD = 6;
  localparam int MIN_MOD   = 10;
  localparam int DIGIT_W   = 4;

  function automatic int digit_mod(input int idx);
    if (idx == 0)      return SEC_U_MOD;
    else if (idx == 1) return SEC_T_MOD;
    else               return MIN_MOD;
  endfunction

endpackage

// File: rtl/timer_mmss_if.sv
// Control/status bundle between the time-entry side (master) and the timer
// (slave).
//   loadn  : active-low synchronous load of in
//   in     : BCD preset, [3:0] sec units, [7:4] sec tens, [11:8] min units, ...
//   start  : level, begin/resume counting
//   pause  : level, suspend counting
//   tick   : one-cycle 1 Hz enable strobe
//   out    : current BCD count (same layout as in)
//   running: high while counting
//   zero   : high when out == 0
//   done   : one-cycle pulse when the count reaches zero by ticking
// Signalling: there is no valid/ready handshake. Every input is sampled on
// each rising clock edge as a level (start, pause, loadn) or a single-cycle
// strobe (tick); the slave can never stall the master, and outputs are
// valid from the edge after the input that caused them.
interface timer_mmss_if #(
  parameter int MIN_DIGITS = 2,
  parameter int W          = 4 * (2 + MIN_DIGITS)
) ();

  logic         loadn;
  logic [W-1:0] in;
  logic         start;
  logic         pause;
  logic         tick;
  logic [W-1:0] out;
  logic         running;
  logic         zero;
  logic         done;

  modport master (
    output loadn, in, start, pause, tick,
    input  out, running, zero, done
  );

  modport slave (
    input  loadn, in, start, pause, tick,
    output out, running, zero, done
  );

endinterface

// File: rtl/timer_mmss_digit.sv
// One down-counting BCD digit of modulus MOD.
//   in/loadn : synchronous active-low load, out-of-range values clamp to MOD-1
//   en       : decrement by one this cycle (borrow in from the digit below)
//   out      : current digit value
//   tc       : borrow out to the next digit (en while this digit is 0)
//   zero     : digit currently 0
module timer_digit
  import timer_mmss_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic [DIGIT_W-1:0] in,
  input  logic               loadn,
  input  logic               clk,
  input  logic               clrn,
  input  logic               en,
  output logic [DIGIT_W-1:0] out,
  output logic               tc,
  output logic               zero
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

  logic [DIGIT_W-1:0] out_q;
  logic [DIGIT_W-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (!loadn) begin
      out_d = (in > MAX_V) ? MAX_V : in;
    end else if (en) begin
      // Decrementing past 0 wraps to MOD-1 and borrows via tc.
      out_d = (out_q == '0) ? MAX_V : (out_q - DIGIT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out  = out_q;
  assign zero = (out_q == '0);
  assign tc   = en & zero;

endmodule

// File: rtl/timer_mmss.sv
// BCD MM:SS countdown timer with run/pause control and completion pulse.
//   clk     : system clock, rising edge
//   clrn    : asynchronous active-low reset
//   bus     : timer_mmss_if slave (load/start/pause/tick in; out/running/
//             zero/done out)
//   state_o : current control FSM state, for observation
// Digit chain: digit 0 is seconds units; each digit's borrow enables the next.
module timer_mmss
  import timer_mmss_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int W          = 4 * (2 + MIN_DIGITS)
) (
  input  logic   clk,
  input  logic   clrn,
  timer_mmss_if.slave bus,
  output state_e state_o
);

  localparam int ND = 2 + MIN_DIGITS;

  state_e       state_q;
  logic         done_q;
  logic [W-1:0] cnt;
  logic [ND-1:0] en;
  logic [ND-1:0] tc;
  logic [ND-1:0] dz;
  logic          count_is_one;
  logic          unused_top_borrow;

  // A decrement only happens on a tick in RUN that is not overridden by a
  // pause or a load in the same cycle.
  assign en[0] = bus.tick & (state_q == ST_RUN) & ~bus.pause & bus.loadn;

  for (genvar i = 0; i < ND; i++) begin : g_digit
    timer_digit #(.MOD(digit_mod(i))) u_digit (
      .in    (bus.in[DIGIT_W*i +: DIGIT_W]),
      .loadn (bus.loadn),
      .clk   (clk),
      .clrn  (clrn),
      .en    (en[i]),
      .out   (cnt[DIGIT_W*i +: DIGIT_W]),
      .tc    (tc[i]),
      .zero  (dz[i])
    );
    if (i < ND - 1) begin : g_chain
      assign en[i+1] = tc[i];
    end
  end

  // RUN is never entered or kept with a zero count, so the top digit can
  // never borrow; its tc is left unconnected.
  assign unused_top_borrow = tc[ND-1];

  assign count_is_one = (cnt == W'(1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else if (!bus.loadn) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.zero) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_q <= ST_PAUSE;
          end else if (bus.tick && count_is_one) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.start && !bus.pause) state_q <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out     = cnt;
  assign bus.zero    = &dz;
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = done_q;
  assign state_o     = state_q;

endmodule
